// File: rtl/test_memoria_pkg.sv
// test_memoria_pkg: shared sizing constants and word type for the test_memoria RAM.
// Rev 1.0
`default_nettype none

package test_memoria_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 4;
  localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

  typedef logic [DATA_W_DEF-1:0] word_t;
endpackage

`default_nettype wire

// File: rtl/test_memoria_array.sv
// test_memoria_array: inferable single-port storage with a write-first read register.
// Rev 1.0
`default_nettype none

module test_memoria_array
  import test_memoria_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              we,
  output logic [DATA_W-1:0] rd
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Contents come from configuration only; reset never touches the array.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: INIT_VAL};

  logic [DATA_W-1:0] rd_d;
  logic [DATA_W-1:0] rd_q;

  always_comb begin
    rd_d = mem_q[addr];
    if (we) begin
      rd_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rd = rd_q;

endmodule

`default_nettype wire

// File: rtl/test_memoria.sv
// test_memoria: single-port write-first RAM; TEST_MEMORIA_OUTREG_EN adds a second output stage.
// Rev 1.0
`default_nettype none

module test_memoria
  import test_memoria_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              wea,
  output logic [DATA_W-1:0] dout
);

  logic              we;
  logic [DATA_W-1:0] rd;

  // The array has no reset of its own, so writes must be masked here.
  assign we = wea & rst_n;

  test_memoria_array #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .INIT_VAL(INIT_VAL)
  ) u_array (
    .clk  (clk),
    .rst_n(rst_n),
    .addr (addr),
    .din  (din),
    .we   (we),
    .rd   (rd)
  );

`ifdef TEST_MEMORIA_OUTREG_EN
  logic [DATA_W-1:0] out_d;
  logic [DATA_W-1:0] out_q;

  always_comb begin
    out_d = rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign dout = out_q;
`else
  assign dout = rd;
`endif

endmodule

`default_nettype wire

// File: tb/tb_test_memoria.sv
// tb_test_memoria: randomized self-checking bench for test_memoria against a latency-queue model.
// Rev 1.0
`default_nettype none

module tb_test_memoria;

`ifdef TEST_MEMORIA_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] addr;
  logic [3:0] din;
  logic       wea;
  logic [3:0] dout;

  int checks   = 0;
  int failures = 0;
  bit done     = 0;

  test_memoria dut (
    .clk  (clk),
    .rst_n(rst_n),
    .addr (addr),
    .din  (din),
    .wea  (wea),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference: word array plus a queue of results, LAT deep, emptied to zero on reset.
  logic [3:0] m_mem  [16];
  logic [3:0] m_pipe [2];
  logic [3:0] m_res;
  logic [3:0] exp_dout;

  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = 4'h0;
    m_pipe[0] = 4'h0;
    m_pipe[1] = 4'h0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pipe[0] = 4'h0;
      m_pipe[1] = 4'h0;
    end else begin
      if (wea) begin
        m_res       = din;
        m_mem[addr] = din;
      end else begin
        m_res = m_mem[addr];
      end
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = m_res;
    end
  end

  assign exp_dout = (LAT == 1) ? m_pipe[0] : m_pipe[1];

  always @(negedge clk) begin
    if (!done) begin
      checks++;
      if (dout !== exp_dout) begin
        failures++;
        $display("FAIL model_cycle t=%0t dout=%h expected=%h", $time, dout, exp_dout);
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s t=%0t dout=%h expected=%h", name, $time, act, want);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] d);
    @(negedge clk);
    #2;
    addr = a;
    din  = d;
    wea  = 1'b1;
  endtask

  task automatic read_lit(input string name, input logic [3:0] a, input logic [3:0] want);
    @(negedge clk);
    #2;
    addr = a;
    wea  = 1'b0;
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    chk(name, dout, want);
  endtask

  initial begin
    rst_n = 1'b0;
    wea   = 1'b1;
    din   = 4'hF;
    addr  = 4'h0;

    repeat (3) @(negedge clk);
    chk("reset_hold", dout, 4'h0);
    #2;
    rst_n = 1'b1;
    wea   = 1'b0;
    din   = 4'h0;

    read_lit("idle_read", 4'h0, 4'h0);

    @(negedge clk);
    #2;
    din = 4'hF;
    repeat (3) @(negedge clk);
    chk("no_enable", dout, 4'h0);

    #2;
    wea = 1'b1;
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    chk("write_first", dout, 4'hF);
    read_lit("mem0_after_write", 4'h0, 4'hF);

    for (int i = 0; i < 16; i++) wr(4'(i), 4'(i));
    for (int i = 15; i >= 0; i--) read_lit("sweep", 4'(i), 4'(i));

    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      #2;
      addr = 4'($urandom_range(0, 15));
      din  = 4'($urandom_range(0, 15));
      wea  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        #1;
        chk("rnd_async_reset", dout, 4'h0);
        #3;
        rst_n = 1'b1;
      end
    end

    wr(4'h3, 4'hA);
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    chk("write_a", dout, 4'hA);
    #2;
    wea   = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_clear", dout, 4'h0);
    #3;
    rst_n = 1'b1;
    read_lit("data_survives_reset", 4'h3, 4'hA);

    @(negedge clk);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
